// File: rtl/riscv_alu.sv
// Registered RV32I execute-stage ALU with zero/non-zero flags for branch resolution.
// Define RISCV_ALU_MUL_EN to enable MUL (code 11) and MULHU (code 12); otherwise those codes are reserved.
module riscv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             NZ
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             z_d, z_q;
  logic             nz_d, nz_q;
  logic [4:0]       shamt_s;

  assign shamt_s = B[4:0];

`ifdef RISCV_ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_s;
  assign prod_s = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`endif

  // Next-result selection; reserved codes fall through to zero so outputs are never X.
  always_comb begin
    result_d = {WIDTH{1'b0}};
    case (ALUControl)
      4'd0:  result_d = A + B;
      4'd1:  result_d = A - B;
      4'd2:  result_d = A & B;
      4'd3:  result_d = A | B;
      4'd4:  result_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd5:  result_d = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd6:  result_d = A ^ B;
      4'd7:  result_d = A >> shamt_s;
      4'd8:  result_d = A << shamt_s;
      4'd9:  result_d = $unsigned($signed(A) >>> shamt_s);
      4'd10: result_d = B;
`ifdef RISCV_ALU_MUL_EN
      4'd11: result_d = prod_s[WIDTH-1:0];
      4'd12: result_d = prod_s[2*WIDTH-1:WIDTH];
`endif
      default: result_d = {WIDTH{1'b0}};
    endcase
  end

  // Flags come from the same next value so they always match the registered result.
  always_comb begin
    z_d  = (result_d == {WIDTH{1'b0}});
    nz_d = ~z_d;
  end

  // Output registers; reset presents a zero result with Z set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= {WIDTH{1'b0}};
      z_q      <= 1'b1;
      nz_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      z_q      <= z_d;
      nz_q     <= nz_d;
    end
  end

  assign result = result_q;
  assign Z      = z_q;
  assign NZ     = nz_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed test-plan steps plus randomized ops vs a reference model.
module tb_riscv_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic [31:0] result;
  logic        Z;
  logic        NZ;

  int n_checks;
  int n_fail;

  riscv_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .result     (result),
    .Z          (Z),
    .NZ         (NZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, m32, p;
    longint sa, sb, sp, q;
    int sh;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    m32 = 64'h1_0000_0000;
    sh  = int'(b % 32);
    p   = 64'd1 << sh;
    sp  = longint'(p);
    case (op)
      4'd0:  return 32'((ua + ub) % m32);
      4'd1:  return 32'((ua + m32 - ub) % m32);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return 32'(ua / p);
      4'd8:  return 32'((ua * p) % m32);
      4'd9: begin
        if (sa >= 0) q = sa / sp;
        else         q = -((-sa + sp - 1) / sp);
        return 32'(q);
      end
      4'd10: return b;
`ifdef RISCV_ALU_MUL_EN
      4'd11: return 32'((ua * ub) % m32);
      4'd12: return 32'((ua * ub) / m32);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait one edge, check result and both flags against the given expectation.
  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    ALUControl = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp);
    check({tag, ".Z"}, {31'd0, Z}, {31'd0, exp == 32'd0});
    check({tag, ".NZ"}, {31'd0, NZ}, {31'd0, exp != 32'd0});
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;

    // Reset held with random inputs across edges.
    rst_n = 1'b0;
    ALUControl = 4'd6;
    A = $urandom;
    B = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("reset.result", result, 32'd0);
    check("reset.Z", {31'd0, Z}, 32'd1);
    check("reset.NZ", {31'd0, NZ}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("xor", 4'd6, 32'd5, 32'd10, 32'd15);
    step("srl", 4'd7, 32'd30, 32'd10, 32'd0);
    step("sll", 4'd8, 32'd5, 32'd10, 32'd5120);
    step("sra_pos", 4'd9, 32'd127, 32'd1, 32'd63);
    step("sra_neg", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
    step("slt_lt", 4'd4, 32'd5, 32'd10, 32'd1);
    step("slt_ge", 4'd4, 32'd10, 32'd5, 32'd0);
    step("slt_neg", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1);
    step("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
    step("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    step("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    step("sll_mask", 4'd8, 32'd1, 32'd33, 32'd2);
    step("passb", 4'd10, 32'd0, 32'h1234_5000, 32'h1234_5000);
    step("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    step("or", 4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    step("rsv13", 4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    step("rsv14", 4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    step("rsv15", 4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
`ifdef RISCV_ALU_MUL_EN
    step("mul", 4'd11, 32'h0001_0000, 32'h0001_0000, 32'd0);
    step("mulhu", 4'd12, 32'h0001_0000, 32'h0001_0000, 32'd1);
    step("mulhu_max", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`else
    step("mul_off", 4'd11, 32'h0001_0000, 32'h0001_0000, 32'd0);
    step("mulhu_off", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
`endif

    // Randomized ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) ra = 32'($urandom_range(0, 3)) - 32'd1;
      step("rand", rop, ra, rb, ref_alu(rop, ra, rb));
    end

    // Mid-stream reset clears outputs without a clock edge.
    step("pre_rst", 4'd6, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.result", result, 32'd0);
    check("async_rst.Z", {31'd0, Z}, 32'd1);
    check("async_rst.NZ", {31'd0, NZ}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 4'd0, 32'd40, 32'd2, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
Name: riscv_alu

Overview:
- Single-cycle-latency, registered 32-bit integer ALU for the RISC-V execute stage.
- Computes one of the RV32I arithmetic, logic, shift or compare operations on A and B, selected by a 4-bit ALUControl code.
- Registers the 32-bit result plus zero/non-zero flags for branch resolution.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported; shift amount is always B[4:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  32  operand A (rs1).
- B  input  32  operand B (rs2 or immediate).
- ALUControl  input  4  operation select.
- result  output  32  registered operation result.
- Z  output  1  registered flag: 1 when result == 0.
- NZ  output  1  registered flag: always the complement of Z.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n = 0: result = 0, Z = 1, NZ = 0, regardless of clk.
- First rising edge after deassertion samples the inputs normally.
- Latency: inputs sampled at rising edge N; result/Z/NZ for them are valid after edge N and held until the next edge. One result per cycle, no stall, no handshake.
- Combinational next value computed from A, B and ALUControl, then registered.
- Z/NZ are derived from the same next value, so they are always consistent with the registered result.
- Op encoding (ALUControl -> next result):
  - 0 ADD: A + B, modulo 2^32, carry discarded.
  - 1 SUB: A - B, modulo 2^32 (0 - 1 = 0xFFFFFFFF).
  - 2 AND: A & B.
  - 3 OR: A | B.
  - 4 SLT: 1 if $signed(A) < $signed(B), else 0.
  - 5 SLTU: 1 if A < B unsigned, else 0.
  - 6 XOR: A ^ B.
  - 7 SRL: A >> B[4:0], zero fill.
  - 8 SLL: A << B[4:0].
  - 9 SRA: A >>> B[4:0], sign fill from A[31].
  - 10 PASSB: B (LUI path).
  - 11 MUL: see Optional Feature.
  - 12 MULHU: see Optional Feature.
  - 13-15 reserved: result 0 (so Z = 1).
- Shifts: only B[4:0] is used; B[31:5] is ignored (shift by 32 is a shift by 0).
- Compare ops return a 32-bit value: bit 0 holds the outcome, bits 31:1 are 0.
- No exceptions or overflow flag; signed overflow wraps silently.
- Reset asserted mid-stream: outputs go to reset values immediately; the in-flight result is discarded.
- No X propagation: all outputs are defined for every ALUControl value.

Optional Feature:
- Macro: RISCV_ALU_MUL_EN.
- Defined:
  - Code 11 = MUL, the low 32 bits of A*B.
  - Code 12 = MULHU, the high 32 bits of unsigned A*B.
  - Both have the same one-cycle registered latency as all other ops.
- Undefined: codes 11 and 12 behave as reserved (result 0, Z = 1, NZ = 0), and no multiplier logic is synthesized.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> result = 0, Z = 1, NZ = 0; assert rst_n = 0 between edges -> outputs clear without waiting for a clock edge.
- Logic/shift sequence, one op per cycle, each checked one edge later:
  - XOR 5,10 -> 15, Z = 0, NZ = 1.
  - SRL 30,10 -> 0, Z = 1, NZ = 0.
  - SLL 5,10 -> 5120.
  - SRA 127,1 -> 63.
  - SRA 0x80000000,4 -> 0xF8000000.
- Compare: SLT 5,10 -> 1; SLT 10,5 -> 0 with Z = 1; SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
- Arithmetic wrap: ADD 0xFFFFFFFF,1 -> 0 with Z = 1; SUB 0,1 -> 0xFFFFFFFF with NZ = 1.
- Shift-amount masking and misc codes:
  - SLL 1,33 -> 2.
  - PASSB 0,0x12345000 -> 0x12345000.
  - Codes 13-15 -> 0, Z = 1.
- Optional feature:
  - With RISCV_ALU_MUL_EN: MUL 0x10000,0x10000 -> 0; MULHU 0x10000,0x10000 -> 1.
  - Without it: code 11 -> 0, Z = 1.
